// File: rtl/uart_bus_responder.sv
// CPU-bus UART: 8N1 receiver with single-byte rx buffer, transmitter with
// holding + shift register, and level-strobe (rdn/wrn) bus handshake.
module uart_bus_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_doe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       overrun,
    output logic       frame_err,
    input  logic       rxd,
    output logic       txd
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // synchronizer and strobe history
    logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
    logic rdn_reg, wrn_reg;

    // receive path
    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [7:0]  rx_buf_reg, rx_buf_next;
    logic        data_ready_reg, data_ready_next;
    logic        overrun_reg, overrun_next;
    logic        frame_err_reg, frame_err_next;
    logic        rx_load, rx_bad_stop, rd_clear;

    // transmit path
    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [7:0]  tx_hold_reg, tx_hold_next;
    logic        tbre_reg, tbre_next;
    logic        tsre_reg, tsre_next;
    logic        txd_reg, txd_next;
    logic        tx_load, wr_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
            rxd_prev_reg <= 1'b1;
            rdn_reg      <= 1'b1;
            wrn_reg      <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= rxd_sync_reg;
            rdn_reg      <= rdn;
            wrn_reg      <= wrn;
        end
    end

    assign rd_clear  = ~rdn_reg & rdn;
    assign wr_accept = wrn_reg & ~wrn & tbre_reg;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_load       = 1'b0;
        rx_bad_stop   = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                rx_bit_next = '0;
                if (rxd_prev_reg && !rxd_sync_reg)
                    rx_state_next = RX_START;
            end
            RX_START: begin
                // mid-start-bit check rejects line glitches
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7)
                        rx_state_next = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_load       = rxd_sync_reg;
                    rx_bad_stop   = ~rxd_sync_reg;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // a byte landing in the same cycle as a read-clear takes priority
    always_comb begin
        rx_buf_next     = rx_buf_reg;
        data_ready_next = data_ready_reg;
        overrun_next    = overrun_reg;
        frame_err_next  = rx_bad_stop;
        if (rx_load) begin
            rx_buf_next     = rx_shift_reg;
            data_ready_next = 1'b1;
            overrun_next    = rd_clear ? 1'b0 : (overrun_reg | data_ready_reg);
        end else if (rd_clear) begin
            data_ready_next = 1'b0;
            overrun_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_buf_reg     <= '0;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            rx_buf_reg     <= rx_buf_next;
            data_ready_reg <= data_ready_next;
            overrun_reg    <= overrun_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tsre_next     = tsre_reg;
        txd_next      = txd_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                txd_next = 1'b1;
                tx_load  = ~tbre_reg;
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    txd_next      = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        txd_next      = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        txd_next      = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_bit_next   = tx_bit_reg + 3'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (!tbre_reg) begin
                        tx_load = 1'b1;
                    end else begin
                        tsre_next     = 1'b1;
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        // back-to-back frames: start bit follows the stop bit directly
        if (tx_load) begin
            tx_shift_next = tx_hold_reg;
            tx_cnt_next   = '0;
            tsre_next     = 1'b0;
            txd_next      = 1'b0;
            tx_state_next = TX_START;
        end
    end

    // tx_load needs tbre=0 and wr_accept needs tbre=1, so they never collide
    always_comb begin
        tbre_next    = tbre_reg;
        tx_hold_next = tx_hold_reg;
        if (tx_load) begin
            tbre_next = 1'b1;
        end else if (wr_accept) begin
            tbre_next    = 1'b0;
            tx_hold_next = bus_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_hold_reg  <= '0;
            tbre_reg     <= 1'b1;
            tsre_reg     <= 1'b1;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_hold_reg  <= tx_hold_next;
            tbre_reg     <= tbre_next;
            tsre_reg     <= tsre_next;
            txd_reg      <= txd_next;
        end
    end

    assign bus_doe    = ~rdn;
    assign bus_dout   = rx_buf_reg;
    assign data_ready = data_ready_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;
    assign tbre       = tbre_reg;
    assign tsre       = tsre_reg;
    assign txd        = txd_reg;

endmodule
